// File: rtl/turn_seq_pkg.sv
// Shared types for the rear-lamp sequencer.
// The lamp pattern function depends on LAMPS, so it lives in the top module.
package turn_seq_pkg;

  typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF} state_t;

endpackage

// File: rtl/turn_signal_seq_if.sv
// Switch inputs and lamp outputs of the turn sequencer.
// The brake line exists only when TURN_SEQ_BRAKE_EN is defined.
interface turn_signal_seq_if #(parameter int LAMPS = 3);

  logic               left;
  logic               right;
  logic               halt;
`ifdef TURN_SEQ_BRAKE_EN
  logic               brake;
`endif
  logic [2*LAMPS-1:0] led;
  logic               step_tick;

`ifdef TURN_SEQ_BRAKE_EN
  modport master (output left, right, halt, brake, input led, step_tick);
  modport slave  (input left, right, halt, brake, output led, step_tick);
`else
  modport master (output left, right, halt, input led, step_tick);
  modport slave  (input left, right, halt, output led, step_tick);
`endif

endinterface

// File: rtl/step_prescaler.sv
// Free-running DIV_W-bit divider; tick is high for the cycle after the count hits all-ones.
module step_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= &cnt;
    end
  end

endmodule

// File: rtl/turn_signal_seq.sv
// Rear-lamp sequencer: outward sweep on turn, all-lamp flash on hazard.
// Optional TURN_SEQ_BRAKE_EN adds a brake input that lights idle lamps steady.
module turn_signal_seq
  import turn_seq_pkg::*;
#(
  parameter int LAMPS      = 3,
  parameter int DIV_W      = 24,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  turn_signal_seq_if.slave bus
);

  localparam int IW = $clog2(LAMPS + 1);
  localparam int N  = 2 * LAMPS;

  state_t          state, nxt_state;
  logic [IW-1:0]   idx, nxt_idx;
  logic [N-1:0]    lit;
  logic            tick;
  logic            brk;
  logic            haz;

  step_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign bus.step_tick = tick;

`ifdef TURN_SEQ_BRAKE_EN
  assign brk = bus.brake;
`else
  assign brk = 1'b0;
`endif

  // idx lamps lit, growing outward from the centre of the bar
  function automatic logic [N-1:0] lamp_pattern(state_t s, logic [IW-1:0] i);
    logic [N-1:0] p;
    p = '0;
    for (int k = 0; k < LAMPS; k++) begin
      if (k < int'(i)) begin
        if (s == LEFT)  p[LAMPS + k]     = 1'b1;
        if (s == RIGHT) p[LAMPS - 1 - k] = 1'b1;
      end
    end
    if (s == HAZ_ON) p = '1;
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      bus.led <= {N{ACTIVE_LOW}};
    end else if (tick) begin
      state   <= nxt_state;
      idx     <= nxt_idx;
      bus.led <= ACTIVE_LOW ? ~lit : lit;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    haz       = bus.halt | (bus.left & bus.right);
    if (haz) begin
      nxt_state = (state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
      nxt_idx   = '0;
    end else if (bus.left) begin
      nxt_state = LEFT;
      nxt_idx   = (state != LEFT) ? IW'(1) : (idx == IW'(LAMPS)) ? '0 : idx + IW'(1);
    end else if (bus.right) begin
      nxt_state = RIGHT;
      nxt_idx   = (state != RIGHT) ? IW'(1) : (idx == IW'(LAMPS)) ? '0 : idx + IW'(1);
    end else begin
      nxt_state = IDLE;
      nxt_idx   = '0;
    end
  end

  // Brake overlays steady light on whichever side is not signalling
  always_comb begin
    lit = lamp_pattern(nxt_state, nxt_idx);
    if (brk) begin
      case (nxt_state)
        IDLE:    lit = '1;
        LEFT:    lit[LAMPS-1:0] = '1;
        RIGHT:   lit[N-1:LAMPS] = '1;
        default: ;
      endcase
    end
  end

endmodule
